// File: rtl/comm_pkg.sv
// Shared FSM state types and default parameter values for the UART packet wrapper.
package comm_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_COLLECT, RX_CHECK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;

  localparam int DEF_NUM_BYTES   = 2;
  localparam int DEF_RESP_BYTES  = 1;
  localparam int DEF_CHK_EN      = 0;
  localparam int DEF_TIMEOUT_CYC = 50000;
endpackage

// File: rtl/comm_timeout_timer.sv
// Inter-byte idle timer: counts enabled clocks since the last restart and flags
// the clock in which the TIMEOUT_CYC-th idle cycle elapses.
module comm_timeout_timer #(
  parameter int TIMEOUT_CYC = comm_pkg::DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart)                    cnt_d = '0;
    else if (enable && cnt_q < LIM) cnt_d = cnt_q + 1'b1;
  end

  assign expired = enable && !restart && (cnt_q == LIM);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_pkt_wrapper.sv
// Frames UART bytes into a double-buffered command word and serialises a
// response word back out, MSB first; receive and transmit run independently.
module uart_pkt_wrapper
  import comm_pkg::*;
#(
  parameter int NUM_BYTES   = DEF_NUM_BYTES,
  parameter int RESP_BYTES  = DEF_RESP_BYTES,
  parameter int CHK_EN      = DEF_CHK_EN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy,
  output logic                    tx_trmt,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  output logic [NUM_BYTES*8-1:0]  cmd,
  output logic                    cmd_rdy,
  input  logic                    clr_cmd_rdy,
  input  logic [RESP_BYTES*8-1:0] resp,
  input  logic                    snd_resp,
  output logic                    resp_busy,
  output logic                    resp_sent,
  output logic                    frame_err,
  output logic                    overrun
);
  localparam int CW = NUM_BYTES * 8;
  localparam int RW = RESP_BYTES * 8;
  localparam logic [2:0] FRAME_LEN = 3'(NUM_BYTES + CHK_EN);
  localparam logic [2:0] PAY_LEN   = 3'(NUM_BYTES);

  rx_state_t     rx_state_q, rx_state_d;
  logic [2:0]    rx_cnt_q, rx_cnt_d;
  logic [CW-1:0] shadow_q, shadow_d, shadow_nxt;
  logic [7:0]    chk_q, chk_d;
  logic          chk_ok_q, chk_ok_d;
  logic [CW-1:0] cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          load, expired, collecting;

  tx_state_t     tx_state_q, tx_state_d;
  logic [1:0]    tx_cnt_q, tx_cnt_d;
  logic [RW-1:0] tx_sr_q, tx_sr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_trmt_q, tx_trmt_d;
  logic          busy_q, busy_d;
  logic          sent_q, sent_d;

  assign clr_rx_rdy = rx_rdy & ~rst;
  assign collecting = (rx_state_q == RX_COLLECT);
  assign shadow_nxt = (shadow_q << 8) | CW'(rx_data);

  comm_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk(clk), .rst(rst), .restart(rx_rdy), .enable(collecting), .expired(expired)
  );

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    shadow_d    = shadow_q;
    chk_d       = chk_q;
    chk_ok_d    = chk_ok_q;
    cmd_d       = cmd_q;
    frame_err_d = 1'b0;
    load        = 1'b0;
    // Checksum verdict was captured with the final byte; CHECK only acts on it.
    if (rx_state_q == RX_CHECK) begin
      rx_state_d = RX_IDLE;
      if (chk_ok_q) begin
        load  = 1'b1;
        cmd_d = shadow_q;
      end else begin
        frame_err_d = 1'b1;
      end
    end
    // A byte may arrive in any state, including CHECK, where it opens a new frame.
    if (rx_rdy) begin
      if (rx_cnt_q < PAY_LEN) begin
        shadow_d = shadow_nxt;
        chk_d    = chk_q ^ rx_data;
      end
      if (rx_cnt_q + 3'd1 == FRAME_LEN) begin
        rx_cnt_d = '0;
        chk_d    = '0;
        if (CHK_EN != 0) begin
          chk_ok_d   = (chk_q == rx_data);
          rx_state_d = RX_CHECK;
        end else begin
          load       = 1'b1;
          cmd_d      = shadow_nxt;
          rx_state_d = RX_IDLE;
        end
      end else begin
        rx_cnt_d   = rx_cnt_q + 3'd1;
        rx_state_d = RX_COLLECT;
      end
    end else if (expired) begin
      rx_cnt_d    = '0;
      chk_d       = '0;
      rx_state_d  = RX_IDLE;
      frame_err_d = 1'b1;
    end
    overrun_d = load & cmd_rdy_q & ~clr_cmd_rdy;
    if (load)             cmd_rdy_d = 1'b1;
    else if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    else                  cmd_rdy_d = cmd_rdy_q;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_sr_d    = tx_sr_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    tx_trmt_d  = 1'b0;
    sent_d     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: if (snd_resp) begin
        tx_data_d  = resp[RW-1 -: 8];
        tx_sr_d    = resp << 8;
        tx_cnt_d   = 2'(RESP_BYTES - 1);
        tx_trmt_d  = 1'b1;
        busy_d     = 1'b1;
        tx_state_d = TX_SEND;
      end
      TX_SEND: tx_state_d = TX_WAIT;
      TX_WAIT: if (tx_done) begin
        if (tx_cnt_q != 2'd0) begin
          tx_data_d  = tx_sr_q[RW-1 -: 8];
          tx_sr_d    = tx_sr_q << 8;
          tx_cnt_d   = tx_cnt_q - 2'd1;
          tx_trmt_d  = 1'b1;
          tx_state_d = TX_SEND;
        end else begin
          sent_d     = 1'b1;
          busy_d     = 1'b0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      shadow_q    <= '0;
      chk_q       <= '0;
      chk_ok_q    <= 1'b0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_sr_q     <= '0;
      tx_data_q   <= '0;
      tx_trmt_q   <= 1'b0;
      busy_q      <= 1'b0;
      sent_q      <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      shadow_q    <= shadow_d;
      chk_q       <= chk_d;
      chk_ok_q    <= chk_ok_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_sr_q     <= tx_sr_d;
      tx_data_q   <= tx_data_d;
      tx_trmt_q   <= tx_trmt_d;
      busy_q      <= busy_d;
      sent_q      <= sent_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign tx_trmt   = tx_trmt_q;
  assign tx_data   = tx_data_q;
  assign resp_busy = busy_q;
  assign resp_sent = sent_q;
endmodule

// File: tb/tb_uart_pkt_wrapper.sv
// Directed bench: instance a (2-byte cmd, 2-byte resp, 100-cycle timeout) and
// instance b (3-byte cmd with checksum), checked against scoreboard queues.
module tb_uart_pkt_wrapper;
  localparam int T = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rx_rdy_a = 0, tx_done_a = 0, clr_cmd_rdy_a = 0, snd_resp_a = 0;
  logic [7:0]  rx_data_a = 0;
  logic [15:0] resp_a = 0;
  logic        clr_rx_rdy_a, tx_trmt_a, cmd_rdy_a, resp_busy_a, resp_sent_a, frame_err_a, overrun_a;
  logic [7:0]  tx_data_a;
  logic [15:0] cmd_a;

  logic        rx_rdy_b = 0, tx_done_b = 0, clr_cmd_rdy_b = 0, snd_resp_b = 0;
  logic [7:0]  rx_data_b = 0;
  logic [7:0]  resp_b = 0;
  logic        clr_rx_rdy_b, tx_trmt_b, cmd_rdy_b, resp_busy_b, resp_sent_b, frame_err_b, overrun_b;
  logic [7:0]  tx_data_b;
  logic [23:0] cmd_b;

  uart_pkt_wrapper #(.NUM_BYTES(2), .RESP_BYTES(2), .CHK_EN(0), .TIMEOUT_CYC(T)) dut_a (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy_a), .rx_data(rx_data_a), .clr_rx_rdy(clr_rx_rdy_a),
    .tx_trmt(tx_trmt_a), .tx_data(tx_data_a), .tx_done(tx_done_a), .cmd(cmd_a),
    .cmd_rdy(cmd_rdy_a), .clr_cmd_rdy(clr_cmd_rdy_a), .resp(resp_a), .snd_resp(snd_resp_a),
    .resp_busy(resp_busy_a), .resp_sent(resp_sent_a), .frame_err(frame_err_a), .overrun(overrun_a));

  uart_pkt_wrapper #(.NUM_BYTES(3), .RESP_BYTES(1), .CHK_EN(1), .TIMEOUT_CYC(T)) dut_b (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy_b), .rx_data(rx_data_b), .clr_rx_rdy(clr_rx_rdy_b),
    .tx_trmt(tx_trmt_b), .tx_data(tx_data_b), .tx_done(tx_done_b), .cmd(cmd_b),
    .cmd_rdy(cmd_rdy_b), .clr_cmd_rdy(clr_cmd_rdy_b), .resp(resp_b), .snd_resp(snd_resp_b),
    .resp_busy(resp_busy_b), .resp_sent(resp_sent_b), .frame_err(frame_err_b), .overrun(overrun_b));

  int errors = 0;
  int checks = 0;
  logic [31:0] cmd_q[$];
  logic [31:0] tx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic byte_a(input logic [7:0] b);
    rx_rdy_a = 1'b1; rx_data_a = b;
    #1 chk("clr_rx_rdy_a", {31'd0, clr_rx_rdy_a}, 32'd1);
    step();
    rx_rdy_a = 1'b0;
  endtask

  task automatic byte_b(input logic [7:0] b);
    rx_rdy_b = 1'b1; rx_data_b = b;
    #1 chk("clr_rx_rdy_b", {31'd0, clr_rx_rdy_b}, 32'd1);
    step();
    rx_rdy_b = 1'b0;
  endtask

  initial begin
    logic seen;
    repeat (3) step();
    chk("rst_cmd", {16'd0, cmd_a}, 32'd0);
    chk("rst_cmd_rdy", {31'd0, cmd_rdy_a}, 32'd0);
    chk("rst_tx_trmt", {31'd0, tx_trmt_a}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data_a}, 32'd0);
    chk("rst_busy", {31'd0, resp_busy_a}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err_a | frame_err_b}, 32'd0);
    rst = 1'b0;
    step();

    // Basic frame and acknowledge
    cmd_q.push_back(32'h1234);
    byte_a(8'h12);
    chk("rdy_after_1st", {31'd0, cmd_rdy_a}, 32'd0);
    byte_a(8'h34);
    chk("rdy_after_2nd", {31'd0, cmd_rdy_a}, 32'd1);
    chk("cmd_1234", {16'd0, cmd_a}, cmd_q.pop_front());
    clr_cmd_rdy_a = 1'b1; step(); clr_cmd_rdy_a = 1'b0;
    chk("rdy_cleared", {31'd0, cmd_rdy_a}, 32'd0);
    chk("cmd_held", {16'd0, cmd_a}, 32'h1234);

    // Overwrite while unacknowledged, then load coinciding with clear
    byte_a(8'hAA); byte_a(8'hAA);
    chk("ovr_first_none", {31'd0, overrun_a}, 32'd0);
    cmd_q.push_back(32'h5555);
    byte_a(8'h55); byte_a(8'h55);
    chk("ovr_pulse", {31'd0, overrun_a}, 32'd1);
    chk("ovr_cmd", {16'd0, cmd_a}, cmd_q.pop_front());
    chk("ovr_rdy", {31'd0, cmd_rdy_a}, 32'd1);
    step();
    chk("ovr_pulse_end", {31'd0, overrun_a}, 32'd0);
    cmd_q.push_back(32'h1111);
    byte_a(8'h11);
    clr_cmd_rdy_a = 1'b1;
    byte_a(8'h11);
    clr_cmd_rdy_a = 1'b0;
    chk("load_wins_rdy", {31'd0, cmd_rdy_a}, 32'd1);
    chk("load_wins_novr", {31'd0, overrun_a}, 32'd0);
    chk("load_wins_cmd", {16'd0, cmd_a}, cmd_q.pop_front());
    clr_cmd_rdy_a = 1'b1; step(); clr_cmd_rdy_a = 1'b0;

    // Inter-byte timeout
    byte_a(8'hFF);
    seen = 1'b0;
    for (int k = 0; k < T; k++) begin
      if (frame_err_a) seen = 1'b1;
      step();
    end
    chk("tmo_not_early", {31'd0, seen}, 32'd0);
    chk("tmo_pulse", {31'd0, frame_err_a}, 32'd1);
    chk("tmo_cmd_kept", {16'd0, cmd_a}, 32'h1111);
    step();
    chk("tmo_pulse_end", {31'd0, frame_err_a}, 32'd0);
    cmd_q.push_back(32'h0000);
    byte_a(8'h00); byte_a(8'h00);
    chk("tmo_next_rdy", {31'd0, cmd_rdy_a}, 32'd1);
    chk("tmo_next_cmd", {16'd0, cmd_a}, cmd_q.pop_front());

    // Reset mid-frame (cmd_rdy still set from previous frame)
    byte_a(8'hBE);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mrst_cmd_rdy", {31'd0, cmd_rdy_a}, 32'd0);
    chk("mrst_cmd", {16'd0, cmd_a}, 32'd0);
    chk("mrst_ferr", {31'd0, frame_err_a}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < T + 10; k++) begin
      if (frame_err_a) seen = 1'b1;
      step();
    end
    chk("mrst_no_err", {31'd0, seen}, 32'd0);
    cmd_q.push_back(32'hBEEF);
    byte_a(8'hBE); byte_a(8'hEF);
    chk("beef_rdy", {31'd0, cmd_rdy_a}, 32'd1);
    chk("beef_cmd", {16'd0, cmd_a}, cmd_q.pop_front());

    // Response transmission
    resp_a = 16'hA5C3;
    tx_q.push_back(32'hA5); tx_q.push_back(32'hC3);
    snd_resp_a = 1'b1; step(); snd_resp_a = 1'b0;
    chk("tx1_trmt", {31'd0, tx_trmt_a}, 32'd1);
    chk("tx1_data", {24'd0, tx_data_a}, tx_q.pop_front());
    chk("tx1_busy", {31'd0, resp_busy_a}, 32'd1);
    tx_done_a = 1'b1; step(); tx_done_a = 0;
    chk("tx_done_in_send", {31'd0, tx_trmt_a}, 32'd0);
    resp_a = 16'h1234;
    snd_resp_a = 1'b1; step(); snd_resp_a = 1'b0;
    chk("snd_while_busy", {31'd0, tx_trmt_a}, 32'd0);
    step(); step();
    tx_done_a = 1'b1; step(); tx_done_a = 1'b0;
    chk("tx2_trmt", {31'd0, tx_trmt_a}, 32'd1);
    chk("tx2_data", {24'd0, tx_data_a}, tx_q.pop_front());
    chk("tx2_nosent", {31'd0, resp_sent_a}, 32'd0);
    step();
    tx_done_a = 1'b1; step(); tx_done_a = 1'b0;
    chk("sent_pulse", {31'd0, resp_sent_a}, 32'd1);
    chk("sent_busy", {31'd0, resp_busy_a}, 32'd0);
    step();
    chk("sent_end", {31'd0, resp_sent_a}, 32'd0);
    chk("no_relaunch", {31'd0, tx_trmt_a | resp_busy_a}, 32'd0);
    chk("tx_q_empty", tx_q.size(), 32'd0);

    // Checksum frames on instance b
    cmd_q.push_back(32'h8BA201);
    byte_b(8'h8B); byte_b(8'hA2); byte_b(8'h01); byte_b(8'h28);
    chk("chk_check_cycle", {31'd0, cmd_rdy_b}, 32'd0);
    step();
    chk("chk_rdy", {31'd0, cmd_rdy_b}, 32'd1);
    chk("chk_cmd", {8'd0, cmd_b}, cmd_q.pop_front());
    clr_cmd_rdy_b = 1'b1; step(); clr_cmd_rdy_b = 1'b0;
    byte_b(8'h8B); byte_b(8'hA2); byte_b(8'h01); byte_b(8'h29);
    chk("bad_chk_early", {31'd0, frame_err_b}, 32'd0);
    step();
    chk("bad_chk_ferr", {31'd0, frame_err_b}, 32'd1);
    chk("bad_chk_cmd", {8'd0, cmd_b}, 32'h8BA201);
    chk("bad_chk_rdy", {31'd0, cmd_rdy_b}, 32'd0);
    step();
    chk("bad_chk_end", {31'd0, frame_err_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_pkt_wrapper.md
UART_PKT_WRAPPER -- requirements
Module: uart_pkt_wrapper

Interface
REQ-001 SHALL have parameter NUM_BYTES, 2, command payload bytes per frame (legal range 1..4).
REQ-002 SHALL have parameter RESP_BYTES, 1, response bytes per transmission (legal range 1..4).
REQ-003 SHALL have parameter CHK_EN, 0, when 1 each frame carries one trailing XOR checksum byte.
REQ-004 SHALL have parameter TIMEOUT_CYC, 50000, maximum idle clocks between bytes of one frame.
REQ-005 SHALL have port clk  in  1  system clock; one clock domain, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-007 SHALL have port rx_rdy  in  1  UART receiver holds a byte.
REQ-008 SHALL have port rx_data  in  8  received byte.
REQ-009 SHALL have port clr_rx_rdy  out  1  one-cycle consume pulse to receiver.
REQ-010 SHALL have port tx_trmt  out  1  one-cycle start pulse to transmitter.
REQ-011 SHALL have port tx_data  out  8  byte to transmit, valid while tx_trmt=1.
REQ-012 SHALL have port tx_done  in  1  one-cycle pulse: transmitter finished a byte.
REQ-013 SHALL have port cmd  out  NUM_BYTES*8  assembled command, first byte in MSBs.
REQ-014 SHALL have port cmd_rdy  out  1  cmd holds an unconsumed frame.
REQ-015 SHALL have port clr_cmd_rdy  in  1  consumer acknowledge.
REQ-016 SHALL have port resp  in  RESP_BYTES*8  response word, sampled on snd_resp.
REQ-017 SHALL have port snd_resp  in  1  start response transmission.
REQ-018 SHALL have ports resp_busy (out, 1, transmission active), resp_sent (out, 1, pulse after last byte), frame_err (out, 1, pulse on dropped frame) and overrun (out, 1, pulse on cmd overwrite).

Function
REQ-019 SHALL assert clr_rx_rdy combinationally in every cycle rx_rdy=1 (exactly one cycle per byte; the receiver drops rx_rdy the next cycle).
REQ-020 SHALL run receive FSM IDLE -> COLLECT -> (CHECK if CHK_EN) -> IDLE, and SHALL shift bytes into a shadow register separate from cmd.
REQ-021 SHALL accept the first byte in IDLE, then stay in COLLECT until NUM_BYTES+CHK_EN bytes have arrived.
REQ-022 SHALL, on the final byte at cycle N, load cmd and set cmd_rdy at N+1 (CHK_EN=0), or at N+2 after a CHECK cycle (CHK_EN=1).
REQ-023 SHALL, when CHK_EN=1, compare XOR of the payload bytes against the checksum byte; on mismatch, leave cmd and cmd_rdy unchanged, pulse frame_err, and return to IDLE.
REQ-024 SHALL reset the inter-byte counter on every accepted byte; if TIMEOUT_CYC clocks pass in COLLECT with no byte, SHALL discard the partial frame, pulse frame_err and return to IDLE.
REQ-025 SHALL keep accepting bytes while cmd_rdy=1 (double-buffered); a frame completing while cmd_rdy=1 overwrites cmd, keeps cmd_rdy=1 and pulses overrun.
REQ-026 SHALL clear cmd_rdy the cycle after clr_cmd_rdy=1; when clr_cmd_rdy coincides with a frame load, the load wins (cmd_rdy stays 1, no overrun pulse).
REQ-027 SHALL hold cmd stable between loads.
REQ-028 SHALL run transmit FSM IDLE -> SEND -> WAIT -> (SEND | IDLE) independently of and concurrently with receive.
REQ-029 SHALL, on snd_resp=1 in IDLE at cycle N, latch resp and assert resp_busy and tx_trmt at N+1 with the most significant byte on tx_data.
REQ-030 SHALL issue the next byte's tx_trmt the cycle after each tx_done, MSB first.
REQ-031 SHALL, on the tx_done of the final byte, pulse resp_sent and drop resp_busy in the next cycle.
REQ-032 SHALL ignore snd_resp while resp_busy=1, and SHALL ignore tx_done outside WAIT.

Reset
REQ-033 SHALL, while rst=1 at a clock edge, force both FSMs to IDLE, clear the counters, shadow register and cmd to 0, and drive cmd_rdy, clr_rx_rdy, tx_trmt, tx_data, resp_busy, resp_sent, frame_err and overrun to 0.
REQ-034 SHALL, when reset occurs mid-frame or mid-response, drop the in-flight data with no error pulse.

Structure
REQ-035 SHALL place rx_state_t, tx_state_t and the default parameter constants in shared package comm_pkg.
REQ-036 SHALL implement the inter-byte timeout as sub-module comm_timeout_timer (restart, enable, expired).

Verification
REQ-037 Defaults; bytes 0x12, 0x34 -> cmd=0x1234, cmd_rdy=1 one cycle after the second byte; clr_cmd_rdy -> cmd_rdy=0 next cycle.
REQ-038 NUM_BYTES=3, CHK_EN=1; bytes 0x8B, 0xA2, 0x01, 0x28 -> cmd=0x8BA201; checksum byte 0x29 instead -> frame_err pulse, cmd unchanged.
REQ-039 TIMEOUT_CYC=100; byte 0xFF, then 100 idle clocks -> frame_err pulse; then 0x00, 0x00 -> cmd=0x0000.
REQ-040 Frame 0xAAAA left unacknowledged, then 0x5555 -> overrun pulse, cmd=0x5555, cmd_rdy=1; clr_cmd_rdy on the load cycle -> cmd_rdy remains 1.
REQ-041 RESP_BYTES=2; resp=0xA5C3 with snd_resp -> tx_data 0xA5 then 0xC3; resp_sent after the second tx_done; a snd_resp while busy is ignored.
REQ-042 rst asserted after one byte of a frame -> all outputs 0; next full frame 0xBEEF assembles correctly.
